instr_mem: RTL and testbench



---
 rtl/instr_mem.sv | 107 ++++++++++
 tb/tb_instr_mem.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// Fetch-side instruction memory with wait states and a preload port.
// Word-organised RAM, one-cycle i_ready pulse per serviced fetch.
module instr_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i_n,
  input  logic [31:0] i_addr,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] instr_read,
  output logic        i_ready,
  output logic        i_fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic        flt_q, flt_d;
  logic [31:0] instr_q, instr_d;
  logic        rflt_q, rflt_d;
  logic        ld_ok;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    flt_d   = flt_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (!cs_i_n) begin
          idx_d   = i_addr[AW+1:2];
          flt_d   = bad_addr(i_addr);
          cnt_d   = WAIT_STATES[3:0];
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The response word is captured on the edge entering RESP, so a
  // same-edge loader write to that index is not seen (read-before-write).
  always_comb begin
    instr_d = instr_q;
    rflt_d  = rflt_q;
    if (state_d == S_RESP) begin
      rflt_d  = flt_d;
      instr_d = flt_d ? RESET_INSTR : mem[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      flt_q   <= 1'b0;
      instr_q <= RESET_INSTR;
      rflt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      flt_q   <= flt_d;
      instr_q <= instr_d;
      rflt_q  <= rflt_d;
    end
  end

  assign ld_ok = ld_en && !bad_addr(ld_addr);

  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr[AW+1:2]] <= ld_data;
  end

  assign instr_read = instr_q;
  assign i_fault    = rflt_q;
  assign i_ready    = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: three instances with 0, 1 and 3
// wait states share clock, reset and loader; a monitor pops expectations.
module tb_instr_mem;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;
  logic        cs0, cs1, cs3;
  logic [31:0] a0, a1, a3;
  logic [31:0] ir0, ir1, ir3;
  logic        rdy0, rdy1, rdy3;
  logic        ft0, ft1, ft3;
  logic        bz0, bz1, bz3;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q0[$], q1[$], q3[$];
  logic [31:0] words [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .cs_i_n(cs0), .i_addr(a0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_read(ir0), .i_ready(rdy0), .i_fault(ft0), .busy(bz0)
  );

  instr_mem #(.WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst), .cs_i_n(cs1), .i_addr(a1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_read(ir1), .i_ready(rdy1), .i_fault(ft1), .busy(bz1)
  );

  instr_mem #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .cs_i_n(cs3), .i_addr(a3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_read(ir3), .i_ready(rdy3), .i_fault(ft3), .busy(bz3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int w, input int c, input logic [31:0] d,
                      input logic f);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    e.f   = f;
    case (w)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic take(input int w, input logic [31:0] d, input logic f);
    exp_t e;
    logic have;
    have = 1'b0;
    case (w)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default:
         if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk($sformatf("spurious_ready_u%0d", w), 32'd1, 32'd0);
    end else begin
      chk($sformatf("resp_cycle_u%0d", w), cyc, e.cyc);
      chk($sformatf("resp_data_u%0d", w), d, e.d);
      chk($sformatf("resp_fault_u%0d", w), {31'd0, f}, {31'd0, e.f});
    end
  endtask

  always @(negedge clk) begin
    if (rdy0) take(0, ir0, ft0);
    if (rdy1) take(1, ir1, ft1);
    if (rdy3) take(3, ir3, ft3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic fetch(input int w, input logic [31:0] a,
                       input logic [31:0] d, input logic f);
    case (w)
      0: begin cs0 = 1'b0; a0 = a; push(0, cyc + 1, d, f); end
      1: begin cs1 = 1'b0; a1 = a; push(1, cyc + 2, d, f); end
      default: begin cs3 = 1'b0; a3 = a; push(3, cyc + 4, d, f); end
    endcase
    tick();
    cs0 = 1'b1;
    cs1 = 1'b1;
    cs3 = 1'b1;
    a0  = 32'hdead_0000;
    a1  = 32'hdead_0000;
    a3  = 32'hdead_0000;
  endtask

  initial begin
    rst = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    cs0 = 1'b1; cs1 = 1'b1; cs3 = 1'b1;
    a0 = '0; a1 = '0; a3 = '0;
    words[0] = 32'h00100093;
    words[1] = 32'h00200113;
    words[2] = 32'h00500093;

    idle(3);
    chk("rst_instr_u1", ir1, NOP);
    chk("rst_ready_u1", {31'd0, rdy1}, 32'd0);
    chk("rst_busy_u1", {31'd0, bz1}, 32'd0);
    chk("rst_fault_u1", {31'd0, ft1}, 32'd0);
    chk("rst_instr_u0", ir0, NOP);
    chk("rst_instr_u3", ir3, NOP);
    rst = 1'b1;
    idle(2);

    load(32'h0, words[0]);
    load(32'h4, words[1]);
    load(32'h8, words[2]);
    load(32'h10, 32'haaaa_0001);
    load(32'hd10, 32'h1234_5678);
    idle(3);

    fetch(1, 32'h8, 32'h00500093, 1'b0);
    idle(4);

    cs0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a0 = 32'(i * 4);
      push(0, cyc + 1, words[i], 1'b0);
      tick();
    end
    cs0 = 1'b1;
    idle(3);

    fetch(1, 32'h2, NOP, 1'b1);
    idle(3);
    fetch(1, 32'h8, 32'h00500093, 1'b0);
    idle(3);
    fetch(1, 32'hffab_cd10, NOP, 1'b1);
    idle(3);
    load(32'hffab_cd10, 32'hdead_beef);
    load(32'h9, 32'hbad0_bad0);
    fetch(1, 32'hd10, 32'h1234_5678, 1'b0);
    idle(4);

    cs3 = 1'b0;
    a3  = 32'h4;
    push(3, cyc + 4, 32'h00200113, 1'b0);
    tick();
    chk("busy_wait_u3", {31'd0, bz3}, 32'd1);
    tick();
    cs3 = 1'b1;
    a3  = 32'h8;
    idle(6);

    cs1 = 1'b0;
    a1  = 32'h10;
    push(1, cyc + 2, 32'haaaa_0001, 1'b0);
    tick();
    cs1 = 1'b1;
    a1  = 32'h8;
    ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'h5555_0002;
    tick();
    ld_en = 1'b0;
    idle(3);
    fetch(1, 32'h10, 32'h5555_0002, 1'b0);
    idle(4);

    cs3 = 1'b0;
    a3  = 32'h0;
    tick();
    cs3 = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_instr_u3", ir3, NOP);
    chk("midrst_busy_u3", {31'd0, bz3}, 32'd0);
    chk("midrst_ready_u3", {31'd0, rdy3}, 32'd0);
    chk("midrst_fault_u3", {31'd0, ft3}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(8);
    fetch(3, 32'h8, 32'h00500093, 1'b0);
    idle(6);

    chk("pending_u0", q0.size(), 32'd0);
    chk("pending_u1", q1.size(), 32'd0);
    chk("pending_u3", q3.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
